// File: rtl/nunchuck_pkg.sv
// Shared types, constants and report packing for the nunchuck I2C target.
package nunchuck_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_A,
    ST_PTR,
    ST_ACK_P,
    ST_WDATA,
    ST_ACK_W,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } state_e;

  localparam logic [6:0] NUNCHUCK_ADDR = 7'h52;
  localparam logic [7:0] HS1_REG = 8'hF0;
  localparam logic [7:0] HS1_VAL = 8'h55;
  localparam logic [7:0] HS2_REG = 8'hFB;
  localparam int REPORT_BYTES = 6;

  typedef logic [8*REPORT_BYTES-1:0] report_t;

  // Byte 0 of the report sits in the top byte.
  function automatic report_t pack_report(
    input logic [7:0] sx,
    input logic [7:0] sy,
    input logic [9:0] ax,
    input logic [9:0] ay,
    input logic [9:0] az,
    input logic       zb,
    input logic       cb
  );
    return {sx, sy, ax[9:2], ay[9:2], az[9:2],
            az[1:0], ay[1:0], ax[1:0], ~cb, ~zb};
  endfunction

  function automatic logic [7:0] report_byte(
    input report_t    r,
    input logic [7:0] ptr,
    input logic       ok
  );
    logic [7:0] b;
    b = 8'hFF;
    if (ok && ptr < 8'(REPORT_BYTES))
      b = 8'(r >> (8 * (REPORT_BYTES - 1 - int'(ptr))));
    return b;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronisers for SCL/SDA with edge and START/STOP pulses.
module i2c_line_sync (
  input  logic clock,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  // [1:0] synchroniser, [2] one-cycle history
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign sda_o      = sda_q[1];
  assign scl_rise_o = scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] & scl_q[2];
  assign start_o    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_o     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_nunchuck_target.sv
// Oversampled I2C target emulating a Wii nunchuck (handshake + 6-byte report).
// Optional SCL stretching on reads is built when CLOCK_STRETCH_EN is defined.
module i2c_nunchuck_target
  import nunchuck_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = NUNCHUCK_ADDR,
  parameter int         HOLD_CYCLES = 4
`ifdef CLOCK_STRETCH_EN
  , parameter int       STRETCH_CYCLES = 64
`endif
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       scl_oe,
  input  logic [7:0] stick_x,
  input  logic [7:0] stick_y,
  input  logic [9:0] accel_x,
  input  logic [9:0] accel_y,
  input  logic [9:0] accel_z,
  input  logic       z,
  input  logic       c,
  output logic       initialized,
  output logic       busy
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_line_sync u_sync (
    .clock      (clock),
    .rst        (rst),
    .scl_i      (scl_in),
    .sda_i      (sda_in),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start),
    .stop_o     (stop)
  );

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    ptr_q, ptr_d;
  logic [7:0]    tx_q, tx_d;
  report_t       snap_q, snap_d;
  logic          hs1_q, hs1_d;
  logic          init_q, init_d;
  logic          busy_q, busy_d;
  logic          oe_q, oe_d;
  logic          pend_q, pend_d;
  logic [HW-1:0] hold_q, hold_d;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      ptr_q   <= '0;
      tx_q    <= '0;
      snap_q  <= '0;
      hs1_q   <= 1'b0;
      init_q  <= 1'b0;
      busy_q  <= 1'b0;
      oe_q    <= 1'b0;
      pend_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ptr_q   <= ptr_d;
      tx_q    <= tx_d;
      snap_q  <= snap_d;
      hs1_q   <= hs1_d;
      init_q  <= init_d;
      busy_q  <= busy_d;
      oe_q    <= oe_d;
      pend_q  <= pend_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    tx_d    = tx_q;
    snap_d  = snap_q;
    hs1_d   = hs1_q;
    init_d  = init_q;
    busy_d  = busy_q;
    oe_d    = oe_q;
    pend_d  = pend_q;
    hold_d  = hold_q;

    // Drive decided at SCL fall lands on the pin after the hold delay.
    if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
      if (hold_q == HW'(1))
        oe_d = pend_q;
    end

    if (stop) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      oe_d    = 1'b0;
      hold_d  = '0;
    end else if (start) begin
      state_d = ST_ADDR;
      cnt_d   = '0;
      busy_d  = 1'b1;
      oe_d    = 1'b0;
      hold_d  = '0;
    end else if (scl_rise) begin
      shift_d = {shift_q[6:0], sda_s};
      cnt_d   = cnt_q + 1'b1;
      case (state_q)
        ST_ADDR: begin
          if (cnt_q == 3'd7)
            state_d = (shift_d[7:1] == DEV_ADDR) ? ST_ACK_A : ST_IGNORE;
        end
        ST_ACK_A: begin
          cnt_d = '0;
          if (shift_q[0]) begin
            snap_d  = pack_report(stick_x, stick_y, accel_x,
                                  accel_y, accel_z, z, c);
            tx_d    = report_byte(snap_d, ptr_q, init_q);
            state_d = ST_RDATA;
          end else begin
            state_d = ST_PTR;
          end
        end
        ST_PTR: begin
          if (cnt_q == 3'd7) begin
            ptr_d   = shift_d;
            state_d = ST_ACK_P;
          end
        end
        ST_ACK_P, ST_ACK_W: begin
          cnt_d   = '0;
          state_d = ST_WDATA;
        end
        ST_WDATA: begin
          if (cnt_q == 3'd7) begin
            if (ptr_q == HS1_REG && shift_d == HS1_VAL)
              hs1_d = 1'b1;
            if (ptr_q == HS2_REG && shift_d == 8'h00 && hs1_q)
              init_d = 1'b1;
            ptr_d   = ptr_q + 8'd1;
            state_d = ST_ACK_W;
          end
        end
        ST_RDATA: begin
          if (cnt_q == 3'd7)
            state_d = ST_RACK;
        end
        ST_RACK: begin
          cnt_d = '0;
          if (!sda_s) begin
            ptr_d = (ptr_q == 8'(REPORT_BYTES - 1)) ?
                    8'd0 : ptr_q + 8'd1;
            tx_d    = report_byte(snap_q, ptr_d, init_q);
            state_d = ST_RDATA;
          end else begin
            state_d = ST_IGNORE;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      hold_d = HW'(HOLD_CYCLES);
      case (state_q)
        ST_ACK_A, ST_ACK_P, ST_ACK_W: pend_d = 1'b1;
        ST_RDATA: pend_d = ~tx_q[3'd7 - cnt_q];
        default:  pend_d = 1'b0;
      endcase
    end
  end

`ifdef CLOCK_STRETCH_EN
  localparam int SW = $clog2(STRETCH_CYCLES + 1);

  logic [SW-1:0] str_q, str_d;

  // Hold SCL low at the start of every read byte.
  always_comb begin
    str_d = str_q;
    if (str_q != '0)
      str_d = str_q - 1'b1;
    if (start || stop)
      str_d = '0;
    else if (scl_fall && state_q == ST_RDATA && cnt_q == '0)
      str_d = SW'(STRETCH_CYCLES);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) str_q <= '0;
    else     str_q <= str_d;
  end

  assign scl_oe = (str_q != '0);
`else
  assign scl_oe = 1'b0;
`endif

  assign sda_oe      = oe_q;
  assign initialized = init_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_nunchuck_target.sv
// Bit-banged I2C controller with a transaction-level nunchuck model.
module tb_i2c_nunchuck_target;

  localparam int HALF = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       scl_m, sda_m;
  logic       scl_in, sda_in, sda_oe, scl_oe;
  logic [7:0] sx, sy;
  logic [9:0] ax, ay, az;
  logic       zb, cb;
  logic       initialized, busy;

  assign scl_in = scl_m & ~scl_oe;
  assign sda_in = sda_m & ~sda_oe;

  i2c_nunchuck_target #(
    .DEV_ADDR    (7'h52),
    .HOLD_CYCLES (4)
`ifdef CLOCK_STRETCH_EN
    , .STRETCH_CYCLES (16)
`endif
  ) dut (
    .clock       (clk),
    .rst         (rst),
    .scl_in      (scl_in),
    .sda_in      (sda_in),
    .sda_oe      (sda_oe),
    .scl_oe      (scl_oe),
    .stick_x     (sx),
    .stick_y     (sy),
    .accel_x     (ax),
    .accel_y     (ay),
    .accel_z     (az),
    .z           (zb),
    .c           (cb),
    .initialized (initialized),
    .busy        (busy)
  );

  int checks   = 0;
  int failures = 0;
  int n_str    = 0;

  logic [7:0] m_ptr;
  logic       m_hs1, m_init;
  logic [7:0] m_sx, m_sy;
  logic [9:0] m_ax, m_ay, m_az;
  logic       m_z, m_c;
  logic [7:0] rd_buf [8];
  logic [7:0] lit [6];
  bit         in_xfer, bus_held, no_drive;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] exp_byte(input logic [7:0] p);
    if (!m_init || p >= 8'd6) return 8'hFF;
    case (p)
      8'd0:    return m_sx;
      8'd1:    return m_sy;
      8'd2:    return m_ax[9:2];
      8'd3:    return m_ay[9:2];
      8'd4:    return m_az[9:2];
      default: return {m_az[1:0], m_ay[1:0], m_ax[1:0], ~m_c, ~m_z};
    endcase
  endfunction

  task automatic model_write(input logic [7:0] d);
    if (m_ptr == 8'hF0 && d == 8'h55) m_hs1 = 1'b1;
    if (m_ptr == 8'hFB && d == 8'h00 && m_hs1) m_init = 1'b1;
    m_ptr = m_ptr + 8'd1;
  endtask

  task automatic clk_bit(input logic b, output logic r);
    int k;
    tick(4);
    sda_m = b;
    tick(HALF - 4);
    scl_m = 1'b1;
    k = 0;
    while (scl_in !== 1'b1 && k < 2000) begin
      tick(1);
      k++;
    end
    chk("scl_release", 32'(scl_in), 32'd1);
    tick(HALF / 2);
    r = sda_in;
    tick(HALF / 2);
    scl_m = 1'b0;
  endtask

  task automatic i2c_start;
    in_xfer = 1'b1;
    sda_m = 1'b1;
    tick(4);
    scl_m = 1'b1;
    tick(HALF);
    sda_m = 1'b0;
    tick(HALF);
    bus_held = 1'b1;
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop;
    bus_held = 1'b0;
    tick(4);
    sda_m = 1'b0;
    tick(HALF - 4);
    scl_m = 1'b1;
    tick(HALF);
    sda_m = 1'b1;
    tick(HALF);
    in_xfer  = 1'b0;
    no_drive = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], r);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic r;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, r);
      d = {d[6:0], r};
    end
    clk_bit(ack, r);
  endtask

  task automatic wr_txn(input int n, input logic [7:0] b0,
                        input logic [7:0] b1);
    logic ack;
    i2c_start;
    write_byte(8'hA4, ack);
    chk("wr_addr_ack", 32'(ack), 32'd0);
    if (n > 0) begin
      write_byte(b0, ack);
      chk("wr_ptr_ack", 32'(ack), 32'd0);
      m_ptr = b0;
    end
    if (n > 1) begin
      write_byte(b1, ack);
      chk("wr_data_ack", 32'(ack), 32'd0);
      model_write(b1);
    end
    i2c_stop;
  endtask

  task automatic snap_model;
    m_sx = sx; m_sy = sy;
    m_ax = ax; m_ay = ay; m_az = az;
    m_z = zb;  m_c = cb;
  endtask

  task automatic rd_txn(input int n, input int chg_at);
    logic ack;
    logic [7:0] d;
    i2c_start;
    write_byte(8'hA5, ack);
    chk("rd_addr_ack", 32'(ack), 32'd0);
    snap_model;
    for (int i = 0; i < n; i++) begin
      if (i == chg_at) sx = ~sx;
      read_byte(d, (i == n - 1));
      rd_buf[i] = d;
      chk($sformatf("rd_byte%0d", i), 32'(d), 32'(exp_byte(m_ptr)));
      if (i != n - 1)
        m_ptr = (m_ptr == 8'd5) ? 8'd0 : m_ptr + 8'd1;
    end
    i2c_stop;
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] d, old_sx;
    rst = 1'b1;
    scl_m = 1'b1; sda_m = 1'b1;
    sx = '0; sy = '0; ax = '0; ay = '0; az = '0; zb = 1'b0; cb = 1'b0;
    m_ptr = '0; m_hs1 = 1'b0; m_init = 1'b0;
    in_xfer = 1'b0; bus_held = 1'b0; no_drive = 1'b0;
    snap_model;
    lit[0] = 8'h80; lit[1] = 8'h7F; lit[2] = 8'hFF;
    lit[3] = 8'h00; lit[4] = 8'h80; lit[5] = 8'h4E;
    tick(4);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_scl_oe", 32'(scl_oe), 32'd0);
    chk("rst_init", 32'(initialized), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick(4);

    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
`ifndef CLOCK_STRETCH_EN
          chk("scl_oe_off", 32'(scl_oe), 32'd0);
`endif
          if (!in_xfer) begin
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_sda_oe", 32'(sda_oe), 32'd0);
            chk("idle_init", 32'(initialized), 32'(m_init));
          end
          if (bus_held) chk("busy", 32'(busy), 32'd1);
          if (no_drive) chk("no_drive", 32'(sda_oe), 32'd0);
        end
      end
`ifdef CLOCK_STRETCH_EN
      begin
        int run;
        run = 0;
        forever begin
          @(negedge clk);
          if (scl_oe) begin
            run++;
          end else if (run != 0) begin
            chk("stretch_len", 32'(run), 32'd16);
            n_str++;
            run = 0;
          end
        end
      end
`endif
    join_none

    wr_txn(1, 8'h00, 8'h00);
    rd_txn(6, -1);
    for (int i = 0; i < 6; i++)
      chk("pre_hs_ff", 32'(rd_buf[i]), 32'hFF);

    no_drive = 1'b1;
    i2c_start;
    write_byte(8'hA6, ack);
    chk("wrong_addr_nack", 32'(ack), 32'd1);
    write_byte(8'h12, ack);
    chk("ignored_nack", 32'(ack), 32'd1);
    i2c_stop;

    wr_txn(2, 8'hF0, 8'h55);
    chk("hs1_only", 32'(initialized), 32'd0);
    wr_txn(2, 8'hFB, 8'h00);
    chk("hs_init", 32'(initialized), 32'd1);

    sx = 8'h80; sy = 8'h7F; ax = 10'h3FF; ay = 10'h000; az = 10'h201;
    zb = 1'b1; cb = 1'b0;
    wr_txn(1, 8'h00, 8'h00);
    rd_txn(6, -1);
    for (int i = 0; i < 6; i++)
      chk($sformatf("report%0d", i), 32'(rd_buf[i]), 32'(lit[i]));

    for (int t = 0; t < 6; t++) begin
      sx = 8'($urandom); sy = 8'($urandom);
      ax = 10'($urandom); ay = 10'($urandom); az = 10'($urandom);
      zb = 1'($urandom); cb = 1'($urandom);
      if ($urandom_range(0, 2) == 0)
        wr_txn(2, 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) != 0)
        wr_txn(1, 8'($urandom_range(0, 7)), 8'h00);
      rd_txn(int'($urandom_range(1, 7)), -1);
    end

    wr_txn(1, 8'h00, 8'h00);
    old_sx = sx;
    rd_txn(7, 1);
    chk("snap_hold", 32'(rd_buf[6]), 32'(old_sx));
    rd_txn(1, -1);

    ay = 10'h000;
    wr_txn(1, 8'h00, 8'h00);
    i2c_start;
    write_byte(8'hA5, ack);
    chk("rst_rd_addr_ack", 32'(ack), 32'd0);
    snap_model;
    for (int i = 0; i < 3; i++) begin
      read_byte(d, 1'b0);
      chk("rst_rd_byte", 32'(d), 32'(exp_byte(m_ptr)));
      m_ptr = m_ptr + 8'd1;
    end
    clk_bit(1'b1, r);
    clk_bit(1'b1, r);
    tick(10);
    chk("pre_rst_oe", 32'(sda_oe), 32'd1);
    bus_held = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_oe", 32'(sda_oe), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_scl", 32'(scl_oe), 32'd0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(HALF);
    m_ptr = '0; m_hs1 = 1'b0; m_init = 1'b0;
    in_xfer = 1'b0;

    rd_txn(2, -1);
    chk("post_rst_ff0", 32'(rd_buf[0]), 32'hFF);
    chk("post_rst_ff1", 32'(rd_buf[1]), 32'hFF);

`ifdef CLOCK_STRETCH_EN
    chk("stretch_seen", 32'(n_str > 0), 32'd1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
